// File: rtl/sd_loader_pkg.sv
// Shared types and defaults for the SD configuration stream loader.
package sd_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN,
    DONE,
    ERR
  } state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int LEN_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 1048576;

endpackage

// File: rtl/sd_bit_packer.sv
// Serial-to-parallel packer: cfg_clk edge detect, MSB-first shift register,
// bit counter and left-justified view of a partial word.
module sd_bit_packer
  import sd_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              cfg_clk_i,
  input  logic              cfg_dat_i,
  output logic              cap_o,
  output logic              word_done_o,
  output logic [DATA_W-1:0] word_o,
  output logic [DATA_W-1:0] partial_o
);

  localparam int BW = $clog2(DATA_W);

  logic              prev_clk_q, prev_clk_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BW:0]       pad;

  always_comb begin
    prev_clk_d  = cfg_clk_i;
    cap_o       = en_i && !prev_clk_q && cfg_clk_i;
    word_o      = {shift_q[DATA_W-2:0], cfg_dat_i};
    word_done_o = cap_o && (bit_cnt_q == BW'(DATA_W - 1));
    // Zero-pad the LSBs so the captured bits sit at the top of the word.
    pad         = (BW+1)'(DATA_W) - {1'b0, bit_cnt_q};
    partial_o   = shift_q << pad;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    if (clear_i || flush_i) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (cap_o) begin
      shift_d   = word_o;
      bit_cnt_d = bit_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_clk_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
    end else begin
      prev_clk_q <= prev_clk_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/sd_stream_loader.sv
// Packs the SD reader's serial config stream into FIFO words, with a one-entry
// pending slot for FIFO-full retries, reader throttling and length tracking.
module sd_stream_loader
  import sd_loader_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_bits_i,
  input  logic              cfg_clk_i,
  input  logic              cfg_dat_i,
  output logic              cfg_hold_o,
  input  logic              fifo_prog_full_i,
  input  logic              fifo_full_i,
  output logic [DATA_W-1:0] fifo_din_o,
  output logic              fifo_wr_en_o,
  output logic              dat_done_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              overflow_o,
  output logic [LEN_W-1:0]  word_cnt_o
);

  localparam int IW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              hold_q, hold_d;

  logic              start_ok, flush, cap_en, cap, word_done, new_word;
  logic [DATA_W-1:0] word, partial, new_data;

  sd_bit_packer #(.DATA_W(DATA_W)) u_packer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (start_ok),
    .en_i        (cap_en),
    .flush_i     (flush),
    .cfg_clk_i   (cfg_clk_i),
    .cfg_dat_i   (cfg_dat_i),
    .cap_o       (cap),
    .word_done_o (word_done),
    .word_o      (word),
    .partial_o   (partial)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    idle_d       = idle_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    wr_en_d      = 1'b0;
    din_d        = din_q;
    word_cnt_d   = word_cnt_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;
    flush        = (state_q == FLUSH);
    cap_en       = (state_q == LOAD) && (rem_q != '0);
    start_ok     = start_i && (len_bits_i != '0) && (state_q inside {IDLE, DONE, ERR});
    new_word     = word_done || flush;
    new_data     = flush ? partial : word;

    // The pending word always goes out before a word completed in the same cycle.
    if (pend_valid_q) begin
      if (!fifo_full_i) begin
        wr_en_d      = 1'b1;
        din_d        = pend_q;
        pend_valid_d = new_word;
        if (new_word) pend_d = new_data;
      end else if (new_word) begin
        overflow_d = 1'b1;
      end
    end else if (new_word) begin
      if (!fifo_full_i) begin
        wr_en_d = 1'b1;
        din_d   = new_data;
      end else begin
        pend_valid_d = 1'b1;
        pend_d       = new_data;
      end
    end

    case (state_q)
      LOAD: begin
        if (cap) begin
          rem_d  = rem_q - LEN_W'(1);
          idle_d = '0;
          if (rem_q == LEN_W'(1)) state_d = word_done ? DRAIN : FLUSH;
        end else if (hold_q) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + IW'(1);
          if (idle_d == IW'(TIMEOUT)) begin
            state_d   = ERR;
            timeout_d = 1'b1;
          end
        end
      end
      FLUSH: state_d = DRAIN;
      DRAIN: begin
        if (!pend_valid_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    if (start_ok) begin
      state_d      = LOAD;
      rem_d        = len_bits_i;
      idle_d       = '0;
      pend_valid_d = 1'b0;
      wr_en_d      = 1'b0;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      overflow_d   = 1'b0;
      word_cnt_d   = '0;
    end else if (wr_en_d && (word_cnt_q != '1)) begin
      word_cnt_d = word_cnt_q + LEN_W'(1);
    end

    busy_d = (state_d == LOAD) || (state_d == FLUSH) || (state_d == DRAIN);
    hold_d = fifo_prog_full_i || pend_valid_q || (state_q != LOAD);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      idle_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      wr_en_q      <= 1'b0;
      din_q        <= '0;
      word_cnt_q   <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      idle_q       <= idle_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
      word_cnt_q   <= word_cnt_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      hold_q       <= hold_d;
    end
  end

  assign cfg_hold_o   = hold_q;
  assign fifo_din_o   = din_q;
  assign fifo_wr_en_o = wr_en_q;
  assign dat_done_o   = done_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;
  assign overflow_o   = overflow_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_sd_stream_loader.sv
// Directed bench for sd_stream_loader: vector table of whole loads plus
// hand-written backpressure, overflow, timeout and reset sequences.
module tb_sd_stream_loader;

  localparam int DATA_W  = 16;
  localparam int LEN_W   = 32;
  localparam int TIMEOUT = 100;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              start_i = 1'b0;
  logic [LEN_W-1:0]  len_bits_i = '0;
  logic              cfg_clk_i = 1'b0;
  logic              cfg_dat_i = 1'b0;
  logic              cfg_hold_o;
  logic              fifo_prog_full_i = 1'b0;
  logic              fifo_full_i = 1'b0;
  logic [DATA_W-1:0] fifo_din_o;
  logic              fifo_wr_en_o;
  logic              dat_done_o;
  logic              busy_o;
  logic              timeout_o;
  logic              overflow_o;
  logic [LEN_W-1:0]  word_cnt_o;

  int total = 0;
  int bad = 0;
  logic [DATA_W-1:0] got[$];

  sd_stream_loader #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .len_bits_i       (len_bits_i),
    .cfg_clk_i        (cfg_clk_i),
    .cfg_dat_i        (cfg_dat_i),
    .cfg_hold_o       (cfg_hold_o),
    .fifo_prog_full_i (fifo_prog_full_i),
    .fifo_full_i      (fifo_full_i),
    .fifo_din_o       (fifo_din_o),
    .fifo_wr_en_o     (fifo_wr_en_o),
    .dat_done_o       (dat_done_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .overflow_o       (overflow_o),
    .word_cnt_o       (word_cnt_o)
  );

  always #10 clk_i = ~clk_i;

  // Record every FIFO write just after the edge that launched it.
  always @(posedge clk_i) begin
    #1;
    if (fifo_wr_en_o === 1'b1) got.push_back(fifo_din_o);
  end

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [63:0]      bits;
    int               n_words;
    logic [63:0]      words;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic sendBit(input logic b);
    cfg_dat_i = b;
    cfg_clk_i = 1'b1;
    @(negedge clk_i);
    cfg_clk_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic sendBits(input logic [63:0] bits, input int n);
    logic [63:0] v;
    v = bits;
    for (int i = 0; i < n; i++) sendBit(v[63-i]);
  endtask

  task automatic applyStimulus(input logic [LEN_W-1:0] len);
    @(negedge clk_i);
    start_i    = 1'b1;
    len_bits_i = len;
    @(negedge clk_i);
    start_i    = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && dat_done_o !== 1'b1; i++) @(negedge clk_i);
  endtask

  task automatic doReset();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_hold"}, 64'(cfg_hold_o), 64'd0);
    checkOutput({tag, "_din"}, 64'(fifo_din_o), 64'd0);
    checkOutput({tag, "_wr_en"}, 64'(fifo_wr_en_o), 64'd0);
    checkOutput({tag, "_done"}, 64'(dat_done_o), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(timeout_o), 64'd0);
    checkOutput({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    checkOutput({tag, "_word_cnt"}, 64'(word_cnt_o), 64'd0);
  endtask

  initial begin
    logic [63:0] w;
    vecs[0] = '{len: 64, bits: 64'hA5A5_3C3C_FFFF_0001, n_words: 4, words: 64'hA5A5_3C3C_FFFF_0001};
    vecs[1] = '{len: 20, bits: 64'hABCD_A000_0000_0000, n_words: 2, words: 64'hABCD_A000_0000_0000};
    vecs[2] = '{len: 16, bits: 64'h1234_0000_0000_0000, n_words: 1, words: 64'h1234_0000_0000_0000};
    vecs[3] = '{len: 17, bits: 64'h8001_8000_0000_0000, n_words: 2, words: 64'h8001_8000_0000_0000};

    cycles(2);
    checkAllZero("reset");
    reset_i = 1'b0;
    cycles(2);
    checkOutput("idle_hold", 64'(cfg_hold_o), 64'd1);

    applyStimulus('0);
    cycles(2);
    checkOutput("len0_ignored_busy", 64'(busy_o), 64'd0);

    for (int v = 0; v < 4; v++) begin
      got.delete();
      applyStimulus(vecs[v].len);
      checkOutput($sformatf("v%0d_busy", v), 64'(busy_o), 64'd1);
      checkOutput($sformatf("v%0d_done_cleared", v), 64'(dat_done_o), 64'd0);
      sendBits(vecs[v].bits, int'(vecs[v].len));
      waitDone(40);
      checkOutput($sformatf("v%0d_done", v), 64'(dat_done_o), 64'd1);
      checkOutput($sformatf("v%0d_nwords", v), 64'(got.size()), 64'(vecs[v].n_words));
      checkOutput($sformatf("v%0d_word_cnt", v), 64'(word_cnt_o), 64'(vecs[v].n_words));
      w = vecs[v].words;
      for (int i = 0; i < vecs[v].n_words && i < got.size(); i++)
        checkOutput($sformatf("v%0d_word%0d", v, i), 64'(got[i]), 64'(w[63-16*i -: 16]));
      checkOutput($sformatf("v%0d_overflow", v), 64'(overflow_o), 64'd0);
      checkOutput($sformatf("v%0d_busy_end", v), 64'(busy_o), 64'd0);
    end

    // Backpressure: prog_full after word 2, FIFO full while word 3 completes.
    got.delete();
    applyStimulus(64);
    sendBits(64'h1111_2222_0000_0000, 32);
    checkOutput("bp_hold_low", 64'(cfg_hold_o), 64'd0);
    fifo_prog_full_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_hold_high", 64'(cfg_hold_o), 64'd1);
    fifo_full_i = 1'b1;
    sendBits(64'h3333_0000_0000_0000, 16);
    cycles(3);
    checkOutput("bp_parked_count", 64'(got.size()), 64'd2);
    fifo_full_i = 1'b0;
    cycles(2);
    checkOutput("bp_retry_count", 64'(got.size()), 64'd3);
    if (got.size() >= 3) checkOutput("bp_retry_word", 64'(got[2]), 64'h3333);
    fifo_prog_full_i = 1'b0;
    sendBits(64'h4444_0000_0000_0000, 16);
    waitDone(40);
    checkOutput("bp_done", 64'(dat_done_o), 64'd1);
    checkOutput("bp_nwords", 64'(got.size()), 64'd4);
    if (got.size() == 4) begin
      checkOutput("bp_word0", 64'(got[0]), 64'h1111);
      checkOutput("bp_word1", 64'(got[1]), 64'h2222);
      checkOutput("bp_word3", 64'(got[3]), 64'h4444);
    end
    checkOutput("bp_overflow", 64'(overflow_o), 64'd0);

    // Overflow: FIFO stuck full, stream ignores hold for two words.
    doReset();
    got.delete();
    fifo_full_i = 1'b1;
    applyStimulus(32);
    sendBits(64'hDEAD_BEEF_0000_0000, 32);
    cycles(2);
    checkOutput("ovf_flag", 64'(overflow_o), 64'd1);
    checkOutput("ovf_no_write", 64'(got.size()), 64'd0);
    checkOutput("ovf_not_done", 64'(dat_done_o), 64'd0);
    fifo_full_i = 1'b0;
    waitDone(20);
    checkOutput("ovf_done", 64'(dat_done_o), 64'd1);
    checkOutput("ovf_nwords", 64'(got.size()), 64'd1);
    if (got.size() >= 1) checkOutput("ovf_pending_word", 64'(got[0]), 64'hDEAD);
    checkOutput("ovf_word_cnt", 64'(word_cnt_o), 64'd1);

    // Timeout: stream stops after 10 bits.
    doReset();
    got.delete();
    applyStimulus(64);
    sendBits(64'hFFC0_0000_0000_0000, 10);
    cycles(90);
    checkOutput("to_not_yet", 64'(timeout_o), 64'd0);
    checkOutput("to_busy_before", 64'(busy_o), 64'd1);
    for (int i = 0; i < 30 && timeout_o !== 1'b1; i++) @(negedge clk_i);
    checkOutput("to_flag", 64'(timeout_o), 64'd1);
    checkOutput("to_busy", 64'(busy_o), 64'd0);
    checkOutput("to_no_write", 64'(got.size()), 64'd0);

    // Reset in the middle of a load, then a clean 16-bit load.
    doReset();
    got.delete();
    applyStimulus(32);
    sendBits(64'hFF80_0000_0000_0000, 9);
    reset_i = 1'b1;
    @(negedge clk_i);
    checkAllZero("midrst");
    reset_i = 1'b0;
    applyStimulus(16);
    sendBits(64'h5A5A_0000_0000_0000, 16);
    waitDone(40);
    checkOutput("midrst_done", 64'(dat_done_o), 64'd1);
    checkOutput("midrst_nwords", 64'(got.size()), 64'd1);
    if (got.size() >= 1) checkOutput("midrst_word", 64'(got[0]), 64'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_stream_loader.md
Name: sd_stream_loader

Overview:
- Sequences the serial configuration stream from the SD-card SPI reader (`cfg_clk`/`cfg_dat`) into the downstream word FIFO.
- Captures bits and packs them MSB-first into DATA_W-bit words, then writes them to the FIFO.
- Throttles the reader through `cfg_hold` when the FIFO nears full.
- Counts a programmed bitstream length and raises `dat_done` when the last word has been written.
- Sits between the `chip` SD reader and the FIFO, replacing the ad-hoc packing logic in the top level.

Parameters:
- DATA_W, 16, FIFO word width in bits (power of 2, ≥ 2).
- LEN_W, 32, width of the bit-length counter.
- TIMEOUT, 1048576, `clk_i` cycles with no `cfg_clk` edge while loading before aborting.

Ports:
- clk_i  in  1  system clock (50 MHz).
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse; latches `len_bits_i` and begins loading.
- len_bits_i  in  LEN_W  total bitstream length in bits; 0 is illegal.
- cfg_clk_i  in  1  serial bit clock from the SD reader, synchronous to `clk_i`.
- cfg_dat_i  in  1  serial data from the SD reader.
- cfg_hold_o  out  1  stall request to the SD reader.
- fifo_prog_full_i  in  1  FIFO programmable-full flag.
- fifo_full_i  in  1  FIFO full flag.
- fifo_din_o  out  DATA_W  FIFO write data.
- fifo_wr_en_o  out  1  FIFO write strobe, one cycle per word.
- dat_done_o  out  1  sticky; high once all words are written.
- busy_o  out  1  high in LOAD, FLUSH or DRAIN.
- timeout_o  out  1  sticky error: stream stalled.
- overflow_o  out  1  sticky error: word completed while the pending slot was occupied.
- word_cnt_o  out  LEN_W  number of words written since `start_i`.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register, counters, pending slot and `prev_clk` cleared.
- Bit capture: a bit is sampled when `prev_clk == 0` and `cfg_clk_i == 1` (rising-edge detect against a registered `prev_clk`).
  - Capture happens only in state LOAD.
  - `shift <= {shift[DATA_W-2:0], cfg_dat_i}`.
  - `bit_cnt` increments and `rem_bits` decrements on each capture.
- Word completion: when `bit_cnt` wraps (DATA_W bits captured), the word goes to output.
  - If the pending slot is empty and `fifo_full_i == 0`: `fifo_wr_en_o = 1` on the next cycle with `fifo_din_o = word`. Capture-to-write latency is 1 cycle.
  - Otherwise, if the slot is empty: the word is stored in the 1-entry pending slot.
  - Otherwise (slot occupied): the word is dropped and `overflow_o` is set.
- Pending slot: retried every cycle; written when `fifo_full_i == 0`.
  - A newly completed word and a pending retry in the same cycle: the pending word is written first, and the new word moves into the slot.
- cfg_hold_o = `fifo_prog_full_i` OR pending slot valid OR state ∉ {LOAD}.
  - Registered, 1-cycle latency.
  - Bits arriving while hold is asserted are still captured.
- State machine:
  - IDLE: `start_i` with `len_bits_i != 0` → LOAD. On entry: latch the length, clear `dat_done_o`, `timeout_o`, `overflow_o` and `word_cnt_o`. `start_i` with a length of 0 is ignored.
  - LOAD: when `rem_bits` reaches 0 → FLUSH if `bit_cnt != 0`, else → DRAIN. If the idle counter reaches TIMEOUT → ERR.
  - The idle counter resets on each captured bit, and while `cfg_hold_o` is high.
  - FLUSH: left-justify the partial word (zero-pad the LSBs) and issue it as a completed word → DRAIN.
  - DRAIN: wait until the pending slot is empty → DONE.
  - DONE: `dat_done_o = 1`; ignore the stream. `start_i` → LOAD (restart).
  - ERR: `timeout_o = 1`, `busy_o = 0`. `start_i` → LOAD.
- `start_i` while `busy_o` is high is ignored.
- `word_cnt_o` increments on each `fifo_wr_en_o` and saturates at all-ones.
- `reset_i` mid-load: everything returns to reset values within one cycle; partial words are discarded and no write is issued.

Decomposition:
- Package `sd_loader_pkg`:
  - state enum {IDLE, LOAD, FLUSH, DRAIN, DONE, ERR}.
  - DATA_W / LEN_W defaults.
- One natural sub-module: `sd_bit_packer` (edge detect, shift register, bit counter, partial-word left-justify).
- FSM, pending slot and flags stay in the top module.

Test Plan:
- Basic load: start, len = 64, 64 bits of 0xA5A5_3C3C_FFFF_0001 with FIFO never full → 4 writes in order: 0xA5A5, 0x3C3C, 0xFFFF, 0x0001; `dat_done_o` = 1; `word_cnt_o` = 4.
- Partial word: len = 20, bits 0xABCD then 4'b1010 → writes 0xABCD, then 0xA000; `dat_done_o` = 1.
- Backpressure: raise `fifo_prog_full_i` after word 2 → `cfg_hold_o` = 1 the next cycle.
  - Additionally hold `fifo_full_i` = 1 while word 3 completes → it is parked; written within 1 cycle of `fifo_full_i` dropping.
  - No data is lost and `overflow_o` = 0.
- Overflow: `fifo_full_i` stuck at 1 and the stream ignores hold for 2 words → `overflow_o` = 1; the first word stays pending.
- Timeout: with TIMEOUT = 100, stop `cfg_clk_i` after 10 bits → `timeout_o` = 1 at cycle 100 after the last edge; `busy_o` = 0; no write issued.
- Reset mid-load: assert `reset_i` after 9 bits → all outputs 0 the next cycle; a new start with len = 16 produces exactly 1 correct word.
